// File: rtl/i2s_tx.sv
// Philips-format I2S transmitter: divides clk down to BCLK/LRCLK and shifts a
// buffered stereo PCM pair out MSB-first, one bit after each LRCLK edge.
module i2s_tx #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int SLOT_WIDTH   = 32,
   parameter int CLK_DIV      = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [SAMPLE_WIDTH-1:0] left_in,
   input  logic [SAMPLE_WIDTH-1:0] right_in,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic                    bclk,
   output logic                    lrclk,
   output logic                    sdata,
   output logic                    frame_start,
   output logic                    underrun
);
   localparam int FRAME_BITS = 2 * SLOT_WIDTH;
   localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CNT_W      = $clog2(FRAME_BITS);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0] SLOT_C   = CNT_W'(SLOT_WIDTH);
   localparam logic [CNT_W-1:0] SW_C     = CNT_W'(SAMPLE_WIDTH);

   logic [DIV_W-1:0]        div_q, div_d;
   logic                    bclk_q, bclk_d;
   logic                    lrclk_q, lrclk_d;
   logic                    sdata_q, sdata_d;
   logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
   logic                    full_q, full_d;
   logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
   logic [SAMPLE_WIDTH-1:0] tx_l_q, tx_l_d, tx_r_q, tx_r_d;
   logic                    frame_start_q, frame_start_d;
   logic                    underrun_q, underrun_d;

   logic             wrap, fall, accept;
   logic [CNT_W-1:0] cnt_next, slot_pos;

   // Handshake: a pair is taken on any clk where in_valid && in_ready; in_ready
   // is simply "holding buffer empty" and never depends on in_valid.
   always_comb begin
      wrap     = (div_q == DIV_LAST);
      fall     = wrap && bclk_q;
      accept   = in_valid && !full_q;
      cnt_next = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + 1'b1;
      slot_pos = (cnt_next >= SLOT_C) ? cnt_next - SLOT_C : cnt_next;

      div_d         = wrap ? '0 : div_q + 1'b1;
      bclk_d        = wrap ? ~bclk_q : bclk_q;
      lrclk_d       = lrclk_q;
      sdata_d       = sdata_q;
      bit_cnt_d     = bit_cnt_q;
      full_d        = full_q;
      hold_l_d      = hold_l_q;
      hold_r_d      = hold_r_q;
      tx_l_d        = tx_l_q;
      tx_r_d        = tx_r_q;
      frame_start_d = 1'b0;
      underrun_d    = 1'b0;

      if (fall) begin
         bit_cnt_d = cnt_next;
         lrclk_d   = (cnt_next >= SLOT_C);
         sdata_d   = 1'b0;
         if (cnt_next == '0) begin
            frame_start_d = 1'b1;
            if (full_q) begin
               tx_l_d = hold_l_q;
               tx_r_d = hold_r_q;
               full_d = 1'b0;
            end else begin
               tx_l_d     = '0;
               tx_r_d     = '0;
               underrun_d = 1'b1;
            end
         end else if (slot_pos != '0 && slot_pos <= SW_C) begin
            // Each slot consumes its own copy MSB-first; position 0 is the I2S delay bit.
            if (cnt_next >= SLOT_C) begin
               sdata_d = tx_r_q[SAMPLE_WIDTH-1];
               tx_r_d  = tx_r_q << 1;
            end else begin
               sdata_d = tx_l_q[SAMPLE_WIDTH-1];
               tx_l_d  = tx_l_q << 1;
            end
         end
      end

      // Frame start samples full_q before this accept lands, so a same-clk accept waits a frame.
      if (accept) begin
         hold_l_d = left_in;
         hold_r_d = right_in;
         full_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q         <= '0;
         bclk_q        <= 1'b0;
         lrclk_q       <= 1'b0;
         sdata_q       <= 1'b0;
         bit_cnt_q     <= CNT_LAST;
         full_q        <= 1'b0;
         hold_l_q      <= '0;
         hold_r_q      <= '0;
         tx_l_q        <= '0;
         tx_r_q        <= '0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         div_q         <= div_d;
         bclk_q        <= bclk_d;
         lrclk_q       <= lrclk_d;
         sdata_q       <= sdata_d;
         bit_cnt_q     <= bit_cnt_d;
         full_q        <= full_d;
         hold_l_q      <= hold_l_d;
         hold_r_q      <= hold_r_d;
         tx_l_q        <= tx_l_d;
         tx_r_q        <= tx_r_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
      end
   end

   assign in_ready    = ~full_q;
   assign bclk        = bclk_q;
   assign lrclk       = lrclk_q;
   assign sdata       = sdata_q;
   assign frame_start = frame_start_q;
   assign underrun    = underrun_q;
endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: a time-based reference of the I2S frame plus a frame
// scoreboard, driven with directed and randomized sample pairs.
module tb_i2s_tx;
   localparam int SW   = 16;
   localparam int SLOT = 32;
   localparam int DIV  = 2;
   localparam int FW   = 2 * SLOT;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [SW-1:0] left_in = '0;
   logic [SW-1:0] right_in = '0;
   logic          in_valid = 1'b0;
   logic          in_ready, bclk, lrclk, sdata, frame_start, underrun;

   i2s_tx #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(SLOT), .CLK_DIV(DIV)) dut (
      .clk(clk), .reset(reset), .left_in(left_in), .right_in(right_in),
      .in_valid(in_valid), .in_ready(in_ready), .bclk(bclk), .lrclk(lrclk),
      .sdata(sdata), .frame_start(frame_start), .underrun(underrun)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // inputs as seen at the last rising edge
   logic          s_reset = 1'b0, s_valid = 1'b0;
   logic [SW-1:0] s_l = '0, s_r = '0;

   // reference: clk edges since reset, holding buffer, words of the current frame
   int            m_n = 0;
   bit            m_init = 0, m_full = 0, m_fs = 0, m_ur = 0;
   logic [SW-1:0] m_hl = '0, m_hr = '0, m_cl = '0, m_cr = '0;
   logic [FW-1:0] exp_q[$];
   logic [FW-1:0] cap = '0, cap_last = '0;
   bit            cap_on = 0;
   int            frames_done = 0;
   logic          prev_bclk = 1'b0;

   function automatic logic [FW-1:0] frame_of(input logic [SW-1:0] l, input logic [SW-1:0] r);
      return (FW'(l) << (FW - 1 - SW)) | (FW'(r) << (SLOT - 1 - SW));
   endfunction

   task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_step();
      bit acc;
      if (s_reset) begin
         m_init = 1; m_n = 0; m_full = 0; m_fs = 0; m_ur = 0;
         m_hl = '0; m_hr = '0; m_cl = '0; m_cr = '0;
         exp_q.delete();
         cap_on = 0;
      end else if (m_init) begin
         acc = s_valid && !m_full;
         m_n++;
         m_fs = 0;
         m_ur = 0;
         if (m_n % (2 * DIV) == 0 && ((m_n / (2 * DIV) - 1) % FW) == 0) begin
            m_fs = 1;
            if (m_full) begin
               m_cl = m_hl; m_cr = m_hr; m_full = 0;
            end else begin
               m_cl = '0; m_cr = '0; m_ur = 1;
            end
            exp_q.push_back(frame_of(m_cl, m_cr));
         end
         if (acc) begin
            m_hl = s_l; m_hr = s_r; m_full = 1;
         end
      end
   endtask

   task automatic monitor_cycle();
      int f, b, p;
      logic e_bclk, e_lr, e_sd;
      logic [SW-1:0] w;
      logic [FW-1:0] exp_f;
      model_step();
      if (!m_init) return;
      f      = m_n / (2 * DIV);
      e_bclk = ((m_n / DIV) % 2) == 1;
      e_lr   = 1'b0;
      e_sd   = 1'b0;
      b      = 0;
      if (f > 0) begin
         b    = (f - 1) % FW;
         e_lr = (b >= SLOT);
         p    = b % SLOT;
         w    = e_lr ? m_cr : m_cl;
         if (p >= 1 && p <= SW) e_sd = w[SW-p];
      end
      check("bclk", FW'(bclk), FW'(e_bclk));
      check("lrclk", FW'(lrclk), FW'(e_lr));
      check("sdata", FW'(sdata), FW'(e_sd));
      check("in_ready", FW'(in_ready), FW'(!m_full));
      check("frame_start", FW'(frame_start), FW'(m_fs));
      check("underrun", FW'(underrun), FW'(m_ur));
      if (f > 0 && bclk === 1'b1 && prev_bclk === 1'b0) begin
         if (b == 0) cap_on = 1;
         cap[FW-1-b] = sdata;
         if (b == FW - 1 && cap_on) begin
            check("sb_depth", FW'(exp_q.size()), FW'(1));
            if (exp_q.size() > 0) begin
               exp_f = exp_q.pop_front();
               check("sb_frame", cap, exp_f);
            end
            cap_last = cap;
            frames_done++;
         end
      end
      prev_bclk = bclk;
   endtask

   task automatic send_pair(input logic [SW-1:0] l, input logic [SW-1:0] r);
      bit rdy;
      int t;
      left_in  = l;
      right_in = r;
      in_valid = 1'b1;
      t = 0;
      do begin
         rdy = in_ready;
         @(negedge clk);
         t++;
      end while (!rdy && t < 2000);
      if (!rdy) check("accept_timeout", FW'(rdy), FW'(1));
   endtask

   task automatic wait_frame_start();
      int t;
      t = 0;
      while (frame_start !== 1'b1 && t < 600) begin
         @(negedge clk);
         t++;
      end
      if (frame_start !== 1'b1) check("frame_start_timeout", FW'(frame_start), FW'(1));
   endtask

   task automatic wait_frames(input int n);
      int fd0, t;
      fd0 = frames_done;
      t = 0;
      while (frames_done < fd0 + n && t < 400 * n) begin
         @(negedge clk);
         t++;
      end
      if (frames_done < fd0 + n) check("frame_wait_timeout", FW'(frames_done - fd0), FW'(n));
   endtask

   task automatic do_reset(input int cyc);
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b0;
      repeat (cyc) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int per, hi;
      logic [SW-1:0] l, r;
      fork
         forever begin
            @(posedge clk);
            s_reset = reset;
            s_valid = in_valid;
            s_l     = left_in;
            s_r     = right_in;
         end
         forever begin
            @(negedge clk);
            monitor_cycle();
         end
      join_none

      // reset values held while reset is asserted
      repeat (3) @(negedge clk);
      check("rst_bclk", FW'(bclk), FW'(0));
      check("rst_lrclk", FW'(lrclk), FW'(0));
      check("rst_sdata", FW'(sdata), FW'(0));
      check("rst_in_ready", FW'(in_ready), FW'(1));
      check("rst_frame_start", FW'(frame_start), FW'(0));
      check("rst_underrun", FW'(underrun), FW'(0));
      reset = 1'b0;

      // idle: frame period and LRCLK duty, silent frames underrun
      wait_frame_start();
      check("idle_underrun", FW'(underrun), FW'(1));
      per = 0;
      hi  = 0;
      for (int i = 1; i <= 400; i++) begin
         @(negedge clk);
         if (lrclk === 1'b1) hi++;
         if (frame_start === 1'b1) begin
            per = i;
            break;
         end
      end
      check("frame_period", FW'(per), FW'(256));
      check("lrclk_high", FW'(hi), FW'(128));

      // known pair loaded before the first frame start
      do_reset(2);
      send_pair(16'hA5C3, 16'h8001);
      in_valid = 1'b0;
      wait_frames(1);
      check("first_frame_bits", cap_last, 64'h52E18000_40008000);

      // back-to-back streaming, then starving after two pairs
      for (int i = 0; i < 6; i++) send_pair(SW'($urandom), SW'($urandom));
      in_valid = 1'b0;
      wait_frames(3);
      for (int i = 0; i < 2; i++) send_pair(SW'($urandom), SW'($urandom));
      in_valid = 1'b0;
      wait_frames(4);

      // valid raised on an empty-buffer frame start: pair goes out one frame later
      wait_frame_start();
      check("fs_empty_underrun", FW'(underrun), FW'(1));
      l = SW'($urandom);
      r = SW'($urandom);
      send_pair(l, r);
      in_valid = 1'b0;
      wait_frames(2);
      check("deferred_pair", cap_last, frame_of(l, r));

      // randomized gaps and data
      for (int i = 0; i < 25; i++) begin
         repeat ($urandom_range(0, 300)) @(negedge clk);
         send_pair(SW'($urandom), SW'($urandom));
         if ($urandom_range(0, 1) == 0) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      wait_frames(2);

      // reset in the middle of a right slot with the buffer full
      send_pair(SW'($urandom), SW'($urandom));
      send_pair(SW'($urandom), SW'($urandom));
      in_valid = 1'b0;
      per = 0;
      while (lrclk !== 1'b1 && per < 400) begin
         @(negedge clk);
         per++;
      end
      repeat (10) @(negedge clk);
      check("pre_reset_full", FW'(in_ready), FW'(0));
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_bclk", FW'(bclk), FW'(0));
      check("mid_rst_lrclk", FW'(lrclk), FW'(0));
      check("mid_rst_sdata", FW'(sdata), FW'(0));
      check("mid_rst_in_ready", FW'(in_ready), FW'(1));
      reset = 1'b0;
      wait_frame_start();
      check("post_rst_underrun", FW'(underrun), FW'(1));
      wait_frames(1);
      check("post_rst_silent", cap_last, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
